// File: rtl/bcd_scan_display.sv
// Multi-digit BCD 7-segment scan driver: latches a packed BCD word and time-multiplexes
// digits onto a shared segment bus. Optional feature macro: LEADING_ZERO_BLANK_EN.
module bcd_scan_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   an_d;
  logic                err_d;
  logic [3:0]          digit;
  logic                blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Divider, digit index and shadow word for the coming edge.
  always_comb begin
    shadow_d = load ? bcd_in : shadow_q;
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
    end
  end

  // Outputs are computed from next-state values so a load shows up on the very next cycle.
  always_comb begin
    err_d = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (shadow_d[4*k +: 4] > 4'd9) err_d = 1'b1;
    end

    digit = shadow_d[{idx_d, 2'b00} +: 4];
    an_d  = '0;
    an_d[idx_d] = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the MS digit down; the selected digit blanks only if it and all above are zero.
    blank = 1'b0;
    begin : lzb
      logic all_zero;
      all_zero = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
        if (shadow_d[4*k +: 4] != 4'd0) all_zero = 1'b0;
        if (k == int'(idx_d) && k != 0) blank = all_zero;
      end
    end
`else
    blank = 1'b0;
`endif

    seg_d = blank ? 7'b0000000 : decode(digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      seg      <= '0;
      an       <= '0;
      err      <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg      <= seg_d;
      an       <= an_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (DIGITS=4, SCAN_DIV=4) with hand-computed vectors.
module tb_bcd_scan_display;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  localparam logic [6:0] S0   = 7'b1111110;
  localparam logic [6:0] S1   = 7'b0110000;
  localparam logic [6:0] S2   = 7'b1101101;
  localparam logic [6:0] S3   = 7'b1111001;
  localparam logic [6:0] S4   = 7'b0110011;
  localparam logic [6:0] S5   = 7'b1011011;
  localparam logic [6:0] S6   = 7'b1011111;
  localparam logic [6:0] S7   = 7'b1110000;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] SDSH = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SZ   = 7'b0000000;
`else
  localparam logic [6:0] SZ   = 7'b1111110;
`endif

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                err;

  bcd_scan_display #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .bcd_in (bcd_in),
    .seg    (seg),
    .an     (an),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_no  = 0;

  task automatic cmp(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @edge %0d: got an=%b seg=%b err=%b, expected an=%b seg=%b err=%b",
               name, edge_no, act.an, act.seg, act.err, req.an, req.seg, req.err);
    end
  endtask

  // Monitor: the DUT presents a fresh output every cycle; compare just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("scan", {an, seg, err}, e);
      end
    end
  end

  // One cycle of stimulus; bcd_in carries junk when load is low to show it is ignored.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] a,
                      input logic [6:0] s, input logic e);
    load   = ld;
    bcd_in = ld ? d : 16'hFFFF;
    exp_q.push_back({a, s, e});
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] a, input logic [6:0] s, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, a, s, e);
  endtask

  initial begin
    // 1: asynchronous reset with no clock edge, then first edge shows digit 0 = 0.
    #1 reset_n = 1'b0;
    #1 cmp("reset_async", {an, seg, err}, {4'b0000, 7'b0000000, 1'b0});
    @(negedge clk);
    @(negedge clk);
    cmp("reset_hold", {an, seg, err}, {4'b0000, 7'b0000000, 1'b0});
    reset_n = 1'b1;
    edge_no = 0;
    step(1'b0, 16'h0, 4'b0001, S0, 1'b0);

    // 2: 1234 scanned LS digit first, wrapping back to digit 0.
    step(1'b1, 16'h1234, 4'b0001, S4, 1'b0);
    step(1'b0, 16'h0,    4'b0001, S4, 1'b0);
    run(4, 4'b0010, S3, 1'b0);
    run(4, 4'b0100, S2, 1'b0);
    run(4, 4'b1000, S1, 1'b0);
    run(4, 4'b0001, S4, 1'b0);

    // 3: invalid code raises err and shows a dash; clearing drops err next cycle.
    step(1'b1, 16'h00A5, 4'b0010, SDSH, 1'b1);
    run(3, 4'b0010, SDSH, 1'b1);
    run(4, 4'b0100, SZ, 1'b1);
    run(4, 4'b1000, SZ, 1'b1);
    step(1'b0, 16'h0, 4'b0001, S5, 1'b1);
    step(1'b1, 16'h0000, 4'b0001, S0, 1'b0);
    run(2, 4'b0001, S0, 1'b0);

    // 4: load coinciding with the advance into digit 2 shows the new data immediately.
    run(4, 4'b0010, SZ, 1'b0);
    step(1'b1, 16'h5678, 4'b0100, S6, 1'b0);
    run(3, 4'b0100, S6, 1'b0);
    run(4, 4'b1000, S5, 1'b0);
    run(4, 4'b0001, S8, 1'b0);
    run(4, 4'b0010, S7, 1'b0);
    run(2, 4'b0100, S6, 1'b0);

    // 5: reset mid-digit clears outputs at once; a load during reset is discarded.
    reset_n = 1'b0;
    load    = 1'b1;
    bcd_in  = 16'h9999;
    #1 cmp("reset_midscan", {an, seg, err}, {4'b0000, 7'b0000000, 1'b0});
    @(negedge clk);
    @(negedge clk);
    cmp("reset_with_load", {an, seg, err}, {4'b0000, 7'b0000000, 1'b0});
    reset_n = 1'b1;
    step(1'b0, 16'h0, 4'b0001, S0, 1'b0);
    run(2, 4'b0001, S0, 1'b0);
    run(1, 4'b0010, SZ, 1'b0);

    // 6: leading zeros above a single digit (blanked only with the blanking feature).
    step(1'b1, 16'h0007, 4'b0010, SZ, 1'b0);
    run(2, 4'b0010, SZ, 1'b0);
    run(4, 4'b0100, SZ, 1'b0);
    run(4, 4'b1000, SZ, 1'b0);
    step(1'b0, 16'h0, 4'b0001, S7, 1'b0);

    load = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
